// File: rtl/demux_1to4_tdm.sv
// Receive side of a 4-slot TDM link: aligns to the frame-sync marker, reassembles
// each frame into a parallel word and pulses on completed frames or framing errors.
module demux_1to4_tdm #(
    parameter int W = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   Din,
    input  logic           Din_valid,
    input  logic           Sync,
    output logic [4*W-1:0] D,
    output logic [1:0]     Sel,
    output logic           D_valid,
    output logic           Frame_err,
    output logic           Locked
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t         state_reg, state_next;
    logic [1:0]     sel_reg, sel_next;
    logic [4*W-1:0] d_reg;
    logic           d_valid_reg;
    logic           frame_err_reg;

    // Slot 3 goes straight from Din into D, so only slots 0..2 need shadowing.
    logic [3*W-1:0] s_reg;

    logic           wr_en;
    logic [1:0]     wr_slot;
    logic           load_d;
    logic           err;
    logic [2:0]     slot_we;

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        wr_en      = 1'b0;
        wr_slot    = 2'd0;
        load_d     = 1'b0;
        err        = 1'b0;

        if (Din_valid) begin
            unique case (state_reg)
                HUNT: begin
                    if (Sync) begin
                        wr_en      = 1'b1;
                        wr_slot    = 2'd0;
                        sel_next   = 2'd1;
                        state_next = LOCKED;
                    end
                end
                LOCKED: begin
                    if (Sync) begin
                        // A sync anywhere but slot 0 aborts the partial frame and restarts it.
                        wr_en    = 1'b1;
                        wr_slot  = 2'd0;
                        sel_next = 2'd1;
                        err      = (sel_reg != 2'd0);
                    end else if (sel_reg == 2'd0) begin
                        err        = 1'b1;
                        state_next = HUNT;
                    end else if (sel_reg == 2'd3) begin
                        load_d   = 1'b1;
                        sel_next = 2'd0;
                    end else begin
                        wr_en    = 1'b1;
                        wr_slot  = sel_reg;
                        sel_next = sel_reg + 2'd1;
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_slot
            assign slot_we[gi] = wr_en && (wr_slot == 2'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_reg[gi*W +: W] <= '0;
                end else if (slot_we[gi]) begin
                    s_reg[gi*W +: W] <= Din;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= HUNT;
            sel_reg       <= 2'd0;
            d_reg         <= '0;
            d_valid_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sel_reg       <= sel_next;
            d_valid_reg   <= load_d;
            frame_err_reg <= err;
            if (load_d) begin
                d_reg <= {Din, s_reg};
            end
        end
    end

    assign D         = d_reg;
    assign Sel       = sel_reg;
    assign D_valid   = d_valid_reg;
    assign Frame_err = frame_err_reg;
    assign Locked    = (state_reg == LOCKED);

endmodule
